// File: rtl/ghost_mode_scheduler_if.sv
// Handshake bundle between the game-tick side, the scheduler and the ghost logic.
// Strobe semantics: tick, level_start, power_pellet, ghost_eaten, ghost_home,
// reverse and score_valid are single-cycle qualifiers sampled on the rising
// edge. There is no back-pressure, so the receiver must take every pulse in
// the cycle it is presented. score_add is meaningful only while score_valid=1.
interface ghost_mode_scheduler_if #(
  parameter int N_GHOSTS = 4
);
  logic                  tick;
  logic                  level_start;
  logic                  power_pellet;
  logic [N_GHOSTS-1:0]   ghost_eaten;
  logic [N_GHOSTS-1:0]   ghost_home;
  logic [N_GHOSTS-1:0]   dispersando;
  logic [N_GHOSTS-1:0]   perseguindo;
  logic [N_GHOSTS-1:0]   assustado;
  logic [N_GHOSTS-1:0]   piscando;
  logic [N_GHOSTS-1:0]   comido;
  logic [N_GHOSTS-1:0]   reverse;
  logic                  score_valid;
  logic [12:0]           score_add;
  // Debug view of the FSMs: phase (0 scatter, 1 chase), 2 bits per ghost.
  logic                  phase_state;
  logic [2*N_GHOSTS-1:0] ghost_state;

  modport master (
    output tick, level_start, power_pellet, ghost_eaten, ghost_home,
    input  dispersando, perseguindo, assustado, piscando, comido, reverse,
    input  score_valid, score_add, phase_state, ghost_state
  );

  modport slave (
    input  tick, level_start, power_pellet, ghost_eaten, ghost_home,
    output dispersando, perseguindo, assustado, piscando, comido, reverse,
    output score_valid, score_add, phase_state, ghost_state
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Scatter/chase wave schedule, frightened timer, per-ghost NORMAL/FRIGHT/EATEN
// tracking, reversal pulses and ghost-eaten scoring. All outputs are registered
// from the next-state values so an input at edge k shows right after edge k.
module ghost_mode_scheduler #(
  parameter int N_GHOSTS      = 4,
  parameter int SCATTER_TICKS = 420,
  parameter int CHASE_TICKS   = 1200,
  parameter int NUM_WAVES     = 4,
  parameter int FRIGHT_TICKS  = 360,
  parameter int FLASH_TICKS   = 120
) (
  input logic                    clk,
  input logic                    reset,
  ghost_mode_scheduler_if.slave  bus
);

  localparam int MAXP = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int CW   = $clog2(MAXP + 1);
  localparam int FW   = $clog2(FRIGHT_TICKS + 2);
  localparam int WW   = (NUM_WAVES > 1) ? $clog2(NUM_WAVES) : 1;

  localparam logic [CW-1:0] SCATTER_LD = CW'(SCATTER_TICKS);
  localparam logic [CW-1:0] CHASE_LD   = CW'(CHASE_TICKS);
  localparam logic [FW-1:0] FRIGHT_LD  = FW'(FRIGHT_TICKS);
  localparam logic [FW-1:0] FLASH_LD   = FW'(FLASH_TICKS);
  localparam logic [WW-1:0] LAST_WAVE  = WW'(NUM_WAVES - 1);

  typedef enum logic {PH_SCATTER = 1'b0, PH_CHASE = 1'b1} phase_t;
  typedef enum logic [1:0] {G_NORMAL = 2'd0, G_FRIGHT = 2'd1, G_EATEN = 2'd2} ghost_t;

  phase_t        phase_q, phase_d;
  logic [WW-1:0] wave_q, wave_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [FW-1:0] ftimer_q, ftimer_d;
  logic [1:0]    eat_q, eat_d;
  ghost_t        ghost_q [N_GHOSTS];
  ghost_t        ghost_d [N_GHOSTS];

  logic                phase_change;
  logic                fright_end;
  logic [1:0]          eat_cnt;
  logic [12:0]         score_sum;
  logic                score_any;
  logic [N_GHOSTS-1:0] rev_d, disp_d, pers_d, assus_d, pisc_d, com_d;

  // Phase schedule: counter frozen while frightened, final chase is permanent.
  always_comb begin
    phase_d      = phase_q;
    wave_d       = wave_q;
    pcnt_d       = pcnt_q;
    phase_change = 1'b0;
    if (bus.tick && ftimer_q == '0) begin
      if (!(phase_q == PH_CHASE && wave_q == LAST_WAVE)) begin
        if (pcnt_q == CW'(1)) begin
          phase_change = 1'b1;
          if (phase_q == PH_SCATTER) begin
            phase_d = PH_CHASE;
            pcnt_d  = CHASE_LD;
          end else begin
            phase_d = PH_SCATTER;
            wave_d  = wave_q + WW'(1);
            pcnt_d  = SCATTER_LD;
          end
        end else begin
          pcnt_d = pcnt_q - CW'(1);
        end
      end
    end
  end

  // Fright timer: a pellet always reloads it, so a pellet beats a same-cycle expiry.
  always_comb begin
    fright_end = bus.tick && (ftimer_q == FW'(1)) && !bus.power_pellet;
    ftimer_d   = ftimer_q;
    if (bus.power_pellet)
      ftimer_d = FRIGHT_LD;
    else if (bus.tick && ftimer_q != '0)
      ftimer_d = ftimer_q - FW'(1);
  end

  // Ghost transitions, reversal and scoring; eats resolve lowest index first.
  always_comb begin
    eat_cnt   = eat_q;
    score_sum = '0;
    score_any = 1'b0;
    rev_d     = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      ghost_d[i] = ghost_q[i];
      case (ghost_q[i])
        G_NORMAL: begin
          if (phase_change || bus.power_pellet) rev_d[i] = 1'b1;
          if (bus.power_pellet && FRIGHT_TICKS > 0) ghost_d[i] = G_FRIGHT;
        end
        G_FRIGHT: begin
          if (bus.ghost_eaten[i]) begin
            ghost_d[i] = G_EATEN;
            score_sum  = score_sum + (13'd200 << eat_cnt);
            score_any  = 1'b1;
            if (eat_cnt != 2'd3) eat_cnt = eat_cnt + 2'd1;
          end else if (fright_end) begin
            ghost_d[i] = G_NORMAL;
          end
        end
        G_EATEN: begin
          if (bus.ghost_home[i]) ghost_d[i] = G_NORMAL;
        end
        default: ghost_d[i] = G_NORMAL;
      endcase
    end
    // Eats in a pellet cycle use the old count; the pellet then clears it.
    eat_d = bus.power_pellet ? 2'd0 : eat_cnt;
  end

  // Mode outputs derived from the next state so they register in lockstep.
  always_comb begin
    disp_d  = '0;
    pers_d  = '0;
    assus_d = '0;
    pisc_d  = '0;
    com_d   = '0;
    for (int i = 0; i < N_GHOSTS; i++) begin
      disp_d[i]  = (ghost_d[i] == G_NORMAL) && (phase_d == PH_SCATTER);
      pers_d[i]  = (ghost_d[i] == G_NORMAL) && (phase_d == PH_CHASE);
      assus_d[i] = (ghost_d[i] == G_FRIGHT);
      pisc_d[i]  = (ghost_d[i] == G_FRIGHT) && (ftimer_d <= FLASH_LD);
      com_d[i]   = (ghost_d[i] == G_EATEN);
    end
  end

  // Debug view of the FSM state.
  always_comb begin
    bus.phase_state = phase_q;
    bus.ghost_state = '0;
    for (int i = 0; i < N_GHOSTS; i++) bus.ghost_state[2*i +: 2] = ghost_q[i];
  end

  // State and output registers; reset and level_start both restart the level.
  always_ff @(posedge clk) begin
    if (reset || bus.level_start) begin
      phase_q         <= PH_SCATTER;
      wave_q          <= '0;
      pcnt_q          <= SCATTER_LD;
      ftimer_q        <= '0;
      eat_q           <= 2'd0;
      for (int i = 0; i < N_GHOSTS; i++) ghost_q[i] <= G_NORMAL;
      bus.dispersando <= '1;
      bus.perseguindo <= '0;
      bus.assustado   <= '0;
      bus.piscando    <= '0;
      bus.comido      <= '0;
      bus.reverse     <= '0;
      bus.score_valid <= 1'b0;
      bus.score_add   <= '0;
    end else begin
      phase_q         <= phase_d;
      wave_q          <= wave_d;
      pcnt_q          <= pcnt_d;
      ftimer_q        <= ftimer_d;
      eat_q           <= eat_d;
      for (int i = 0; i < N_GHOSTS; i++) ghost_q[i] <= ghost_d[i];
      bus.dispersando <= disp_d;
      bus.perseguindo <= pers_d;
      bus.assustado   <= assus_d;
      bus.piscando    <= pisc_d;
      bus.comido      <= com_d;
      bus.reverse     <= rev_d;
      bus.score_valid <= score_any;
      bus.score_add   <= score_any ? score_sum : 13'd0;
    end
  end

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler: each step drives one cycle of inputs
// and queues the hand-computed outputs expected after that edge; a monitor pops
// and compares after every rising edge.
module tb_ghost_mode_scheduler;

  localparam int W = 38;
  localparam logic [3:0] Z = 4'b0000;
  localparam logic [3:0] F = 4'b1111;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pop    = 0;
  logic [W-1:0] exp_q[$];

  ghost_mode_scheduler_if #(.N_GHOSTS(4)) bus ();

  ghost_mode_scheduler #(
    .N_GHOSTS(4), .SCATTER_TICKS(3), .CHASE_TICKS(5), .NUM_WAVES(2),
    .FRIGHT_TICKS(4), .FLASH_TICKS(2)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input logic [3:0] d, c, a, f, m, r,
                                      input logic sv, input logic [12:0] sa);
    return {d, c, a, f, m, r, sv, sa};
  endfunction

  // Driver: apply one cycle of inputs and queue the expected outputs.
  task automatic step(input logic r, lv, t, p, input logic [3:0] e, h,
                      input logic [W-1:0] x);
    rst              = r;
    bus.level_start  = lv;
    bus.tick         = t;
    bus.power_pellet = p;
    bus.ghost_eaten  = e;
    bus.ghost_home   = h;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor and scoreboard.
  initial begin
    logic [W-1:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {bus.dispersando, bus.perseguindo, bus.assustado, bus.piscando,
                bus.comido, bus.reverse, bus.score_valid, bus.score_add};
        n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL outputs#%0d: got disp=%b pers=%b assus=%b pisc=%b com=%b rev=%b sv=%b sa=%0d, expected disp=%b pers=%b assus=%b pisc=%b com=%b rev=%b sv=%b sa=%0d",
                   n_pop, got[37:34], got[33:30], got[29:26], got[25:22], got[21:18],
                   got[17:14], got[13], got[12:0], want[37:34], want[33:30], want[29:26],
                   want[25:22], want[21:18], want[17:14], want[13], want[12:0]);
        end
        n_pop++;
      end
    end
  end

  // Stimulus: directed scenarios.
  initial begin
    // reset state
    step(1, 0, 0, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(1, 0, 0, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    // schedule: 3 scatter, 5 chase, 3 scatter, permanent chase
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, F, 0, 0));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, F, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, F, 0, 0));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));

    // fright during wave-0 chase; phase counter must resume where it paused
    step(0, 1, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, F, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 1, Z, Z, ev(Z, Z, F, Z, Z, F, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, F, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, F, F, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, F, F, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, F, 0, 0));

    // eat chain with timers frozen (tick=0)
    step(0, 1, 0, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 0, 1, Z, Z, ev(Z, Z, F, Z, Z, F, 0, 0));
    step(0, 0, 0, 0, 4'b0001, Z, ev(Z, Z, 4'b1110, Z, 4'b0001, Z, 1, 200));
    step(0, 0, 0, 0, 4'b0010, Z, ev(Z, Z, 4'b1100, Z, 4'b0011, Z, 1, 400));
    step(0, 0, 0, 0, Z, Z, ev(Z, Z, 4'b1100, Z, 4'b0011, Z, 0, 0));
    step(0, 0, 0, 0, Z, 4'b0001, ev(4'b0001, Z, 4'b1100, Z, 4'b0010, Z, 0, 0));
    // home on a FRIGHT ghost and eat on a NORMAL ghost are both ignored
    step(0, 0, 0, 0, 4'b0001, 4'b0100, ev(4'b0001, Z, 4'b1100, Z, 4'b0010, Z, 0, 0));
    // home with pellet: ghost 1 returns NORMAL; only ghost 0 reverses
    step(0, 0, 0, 1, Z, 4'b0010, ev(4'b0010, Z, 4'b1101, Z, Z, 4'b0001, 0, 0));
    step(0, 0, 0, 1, Z, Z, ev(Z, Z, F, Z, Z, 4'b0010, 0, 0));
    // four eats in one cycle: 200+400+800+1600
    step(0, 0, 0, 0, F, Z, ev(Z, Z, Z, Z, F, Z, 1, 3000));
    step(0, 0, 0, 0, Z, Z, ev(Z, Z, Z, Z, F, Z, 0, 0));
    step(0, 0, 0, 0, Z, 4'b0001, ev(4'b0001, Z, Z, Z, 4'b1110, Z, 0, 0));
    step(0, 0, 0, 1, Z, Z, ev(Z, Z, 4'b0001, Z, 4'b1110, 4'b0001, 0, 0));
    step(0, 0, 0, 0, 4'b0001, Z, ev(Z, Z, Z, Z, F, Z, 1, 200));
    step(0, 0, 0, 0, Z, F, ev(F, Z, Z, Z, Z, Z, 0, 0));

    // pellet restart with one tick of fright left, eat on the same cycle
    step(0, 1, 0, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 0, 1, Z, Z, ev(Z, Z, F, Z, Z, F, 0, 0));
    step(0, 0, 1, 0, 4'b0001, Z, ev(Z, Z, 4'b1110, Z, 4'b0001, Z, 1, 200));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, 4'b1110, 4'b1110, 4'b0001, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, 4'b1110, 4'b1110, 4'b0001, Z, 0, 0));
    step(0, 0, 1, 1, 4'b0010, Z, ev(Z, Z, 4'b1100, Z, 4'b0011, Z, 1, 400));
    step(0, 0, 1, 0, 4'b0100, Z, ev(Z, Z, 4'b1000, Z, 4'b0111, Z, 1, 200));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, 4'b1000, 4'b1000, 4'b0111, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, Z, 4'b1000, 4'b1000, 4'b0111, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(4'b1000, Z, Z, Z, 4'b0111, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(4'b1000, Z, Z, Z, 4'b0111, Z, 0, 0));

    // reset mid-fright with eaten ghosts, then the schedule restarts cleanly
    step(0, 0, 0, 1, Z, Z, ev(Z, Z, 4'b1000, Z, 4'b0111, 4'b1000, 0, 0));
    step(1, 0, 1, 1, F, F, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(F, Z, Z, Z, Z, Z, 0, 0));
    step(0, 0, 1, 0, Z, Z, ev(Z, F, Z, Z, Z, F, 0, 0));
    step(0, 0, 0, 0, Z, Z, ev(Z, F, Z, Z, Z, Z, 0, 0));

    // let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
